ram_io_responder: RTL



---
 rtl/ram_io_responder_if.sv | 27 ++
 rtl/ram_io_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ram_io_responder_if.sv
// Byte-serial memory bus plus TX/RX host byte streams seen by ram_io_responder.
interface ram_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        io_stall;
    logic        sim_halt;

    // Responder side
    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        output mem_din, tx_data, tx_valid, rx_ready, io_stall, sim_halt
    );

    // Controller / host side
    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        input  mem_din, tx_data, tx_valid, rx_ready, io_stall, sim_halt
    );
endinterface

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped I/O window (TX/RX byte FIFOs, status, halt)
// answering the CPU memory controller's byte-serial bus.
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    ram_io_responder_if.slave bus
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL_CNT = (TXW+1)'(TX_DEPTH);
    localparam logic [RXW:0] RX_FULL_CNT = (RXW+1)'(RX_DEPTH);
    localparam logic [31:0]  DATA_ADDR   = 32'h0003_0000;
    localparam logic [31:0]  STAT_ADDR   = 32'h0003_0004;

    logic [7:0] ram    [2**ADDR_WIDTH];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TXW-1:0] tx_rd_ptr, tx_wr_ptr;
    logic [TXW:0]   tx_count;
    logic [RXW-1:0] rx_rd_ptr, rx_wr_ptr;
    logic [RXW:0]   rx_count;

    logic       overflow;
    logic       halt_q;
    logic       data_rd_prev;
    logic [7:0] din_q;

    logic                  io_sel, is_data, is_stat;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_pop, tx_push_req, tx_push;
    logic                  data_rd, rx_strobe, rx_pop, rx_push;
    logic [7:0]            status;

    // Address decode, FIFO flags and handshake qualification
    always_comb begin
        io_sel      = (bus.mem_a[17:16] == 2'b11);
        is_data     = (bus.mem_a == DATA_ADDR);
        is_stat     = (bus.mem_a == STAT_ADDR);
        ram_idx     = bus.mem_a[ADDR_WIDTH-1:0];
        tx_full     = (tx_count == TX_FULL_CNT);
        tx_empty    = (tx_count == '0);
        rx_full     = (rx_count == RX_FULL_CNT);
        rx_empty    = (rx_count == '0);
        tx_pop      = !tx_empty && bus.tx_ready;
        tx_push_req = bus.mem_wr && is_data;
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        data_rd     = is_data && !bus.mem_wr;
        rx_strobe   = data_rd && !data_rd_prev;
        rx_pop      = rx_strobe && !rx_empty;
        rx_push     = bus.rx_valid && !rx_full;
        status      = {5'b0, overflow, !rx_empty, tx_full};
    end

    // RAM array write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (bus.mem_wr && !io_sel)
            ram[ram_idx] <= bus.mem_dout;
    end

    // FIFO storage writes (contents not reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= bus.mem_dout;
        if (rx_push)
            rx_mem[rx_wr_ptr] <= bus.rx_data;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)
                tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop)
                tx_count <= tx_count - 1'b1;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)
                rx_count <= rx_count + 1'b1;
            else if (!rx_push && rx_pop)
                rx_count <= rx_count - 1'b1;
        end
    end

    // Sticky flags and DATA read edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow     <= 1'b0;
            halt_q       <= 1'b0;
            data_rd_prev <= 1'b0;
        end else begin
            data_rd_prev <= data_rd;
            if (tx_push_req && tx_full && !tx_pop)
                overflow <= 1'b1;
            if (bus.mem_wr && is_stat)
                halt_q <= 1'b1;
        end
    end

    // Registered read data; writes and held DATA reads keep the previous byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= '0;
        end else if (!bus.mem_wr) begin
            if (!io_sel)
                din_q <= ram[ram_idx];
            else if (is_data) begin
                // only the strobe cycle samples RX so a held address keeps the popped byte
                if (rx_strobe)
                    din_q <= rx_empty ? '0 : rx_mem[rx_rd_ptr];
            end else if (is_stat)
                din_q <= status;
            else
                din_q <= '0;
        end
    end

    assign bus.mem_din  = din_q;
    assign bus.tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full;
    assign bus.io_stall = tx_full;
    assign bus.sim_halt = halt_q;
endmodule
